// File: rtl/repeated_subtractor.sv
// Unsigned divider by repeated subtraction: one subtract per clock until the partial remainder drops below the divisor.
// Latency: done pulses Q+1 cycles after the accepted start (next cycle for divide-by-zero); start is ignored while busy.
module repeated_subtractor #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  done,
    output logic                  busy,
    output logic                  div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        SUBTRACT,
        FINISH
    } state_t;

    state_t                  state, state_nxt;
    logic [DIVIDEND_W-1:0]   rem_reg, rem_nxt;
    logic [DIVIDEND_W-1:0]   quo_reg, quo_nxt;
    logic [DIVISOR_W-1:0]    dvs_reg, dvs_nxt;
    logic [DIVIDEND_W-1:0]   quotient_nxt;
    logic [DIVISOR_W-1:0]    remainder_nxt;
    logic                    done_nxt;
    logic                    dbz_nxt;
    logic [DIVIDEND_W-1:0]   dvs_ext;

    assign dvs_ext = DIVIDEND_W'(dvs_reg);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            rem_reg     <= rem_nxt;
            quo_reg     <= quo_nxt;
            dvs_reg     <= dvs_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem_reg;
        quo_nxt       = quo_reg;
        dvs_nxt       = dvs_reg;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;
        done_nxt      = 1'b0;
        dbz_nxt       = div_by_zero;
        case (state)
            IDLE: begin
                if (start) begin
                    rem_nxt = dividend;
                    dvs_nxt = divisor;
                    quo_nxt = '0;
                    if (divisor == '0) begin
                        state_nxt     = FINISH;
                        quotient_nxt  = '1;
                        remainder_nxt = '0;
                        dbz_nxt       = 1'b1;
                        done_nxt      = 1'b1;
                    end else begin
                        state_nxt = SUBTRACT;
                    end
                end
            end
            SUBTRACT: begin
                if (rem_reg >= dvs_ext) begin
                    rem_nxt = rem_reg - dvs_ext;
                    quo_nxt = quo_reg + 1'b1;
                end else begin
                    // Visible results (including the error flag) only move at completion.
                    quotient_nxt  = quo_reg;
                    remainder_nxt = rem_reg[DIVISOR_W-1:0];
                    dbz_nxt       = 1'b0;
                    done_nxt      = 1'b1;
                    state_nxt     = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
